dcm_phase_shift_ctrl: RTL and testbench

Steps the variable phase-shift port of the ADC0 capture DCM one tap at a time on request, runs the PSEN/PSDONE handshake, and tracks the signed cumulative offset. Sits in the `dcm_psclk` domain next to the ADC clock-sync FSM. Software or the sync logic can trim the capture-clock phase after DCM lock without resetting the ADCs.

---
 rtl/dcm_phase_shift_ctrl_pkg.sv | 22 ++
 rtl/dcm_phase_shift_ctrl_timer.sv | 29 ++
 rtl/dcm_phase_shift_ctrl.sv | 133 +++++++++++++
 tb/tb_dcm_phase_shift_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/dcm_phase_shift_ctrl_pkg.sv
// Shared definitions for the DCM variable phase-shift controller.
//   - one-hot FSM state encodings
//   - default offset limit / PSDONE timeout for the Virtex DCM
//   - helper: does a step in the given direction leave the offset window?
package dcm_phase_shift_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'b001,
    ST_ISSUE     = 3'b010,
    ST_WAIT_DONE = 3'b100
  } ps_state_e;

  localparam int VIRTEX_DCM_MAX_OFFSET   = 255;
  localparam int VIRTEX_DCM_DONE_TIMEOUT = 1023;

  // True when the offset already sits on the limit in the stepping direction.
  function automatic logic ps_at_limit(input logic dir, input int offset,
                                       input int max_offset);
    return dir ? (offset >= max_offset) : (offset <= -max_offset);
  endfunction

endpackage

// File: rtl/dcm_phase_shift_ctrl_timer.sv
// ps_step_timer: clearable saturating up-counter with a terminal-count flag.
// Ports:
//   dcm_psclk  in  clock
//   ctrl_reset in  synchronous active-high reset
//   clr        in  restart the count at 0
//   en         in  count one per cycle (stops at TC)
//   tc         out count has reached TC
module ps_step_timer #(
  parameter int TC = 1023
) (
  input  logic dcm_psclk,
  input  logic ctrl_reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = (TC > 0) ? $clog2(TC + 1) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge dcm_psclk) begin
    if (ctrl_reset || clr) cnt <= '0;
    else if (en && !tc)    cnt <= cnt + W'(1);
  end

  assign tc = (cnt == W'(TC));

endmodule

// File: rtl/dcm_phase_shift_ctrl.sv
// dcm_phase_shift_ctrl: steps the DCM variable phase shift one tap at a time,
// runs the PSEN/PSDONE handshake and tracks the signed cumulative offset.
// Ports:
//   dcm_psclk, ctrl_reset      clock, synchronous active-high reset
//   dcm_locked                 DCM LOCKED (dcm_psclk domain)
//   cmd_valid/cmd_ready        command handshake; cmd_dir 1=inc, cmd_steps taps
//   err_clr                    clears sticky error flags
//   dcm_psen/dcm_psincdec      DCM phase-shift controls (registered)
//   dcm_psdone                 DCM phase-shift done
//   phase_offset               signed taps applied since reset
//   busy, err_timeout, err_limit
module dcm_phase_shift_ctrl
  import dcm_phase_shift_ctrl_pkg::*;
#(
  parameter int STEP_W       = 8,
  parameter int OFFSET_W     = 10,
  parameter int MAX_OFFSET   = VIRTEX_DCM_MAX_OFFSET,
  parameter int DONE_TIMEOUT = VIRTEX_DCM_DONE_TIMEOUT
) (
  input  logic                       dcm_psclk,
  input  logic                       ctrl_reset,
  input  logic                       dcm_locked,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_dir,
  input  logic [STEP_W-1:0]          cmd_steps,
  input  logic                       err_clr,
  output logic                       dcm_psen,
  output logic                       dcm_psincdec,
  input  logic                       dcm_psdone,
  output logic signed [OFFSET_W-1:0] phase_offset,
  output logic                       busy,
  output logic                       err_timeout,
  output logic                       err_limit
);

  ps_state_e                 state, state_nxt;
  logic [STEP_W-1:0]         rem, rem_nxt;
  logic                      dir_nxt;
  logic signed [OFFSET_W-1:0] off_nxt;
  logic                      set_lim, set_to;
  logic                      tmr_tc;

  // Timer restarts on every PSEN cycle and counts while waiting for PSDONE.
  ps_step_timer #(.TC(DONE_TIMEOUT)) u_timer (
    .dcm_psclk  (dcm_psclk),
    .ctrl_reset (ctrl_reset),
    .clr        (state == ST_ISSUE),
    .en         (state == ST_WAIT_DONE),
    .tc         (tmr_tc)
  );

  assign cmd_ready = (state == ST_IDLE) & dcm_locked;

  always_ff @(posedge dcm_psclk) begin
    if (ctrl_reset) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    dir_nxt   = dcm_psincdec;
    off_nxt   = phase_offset;
    set_lim   = 1'b0;
    set_to    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cmd_valid && dcm_locked) begin
          dir_nxt = cmd_dir;
          rem_nxt = cmd_steps;
          if (cmd_steps != '0) begin
            if (ps_at_limit(cmd_dir, int'(phase_offset), MAX_OFFSET)) begin
              set_lim = 1'b1;
              rem_nxt = '0;
            end else begin
              state_nxt = ST_ISSUE;
            end
          end
        end
      end
      ST_ISSUE: state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        // PSDONE outranks both unlock and timeout.
        if (dcm_psdone) begin
          off_nxt = dcm_psincdec ? phase_offset + OFFSET_W'(1)
                                 : phase_offset - OFFSET_W'(1);
          rem_nxt = rem - STEP_W'(1);
          if (rem == STEP_W'(1)) begin
            state_nxt = ST_IDLE;
          end else if (ps_at_limit(dcm_psincdec, int'(off_nxt), MAX_OFFSET)) begin
            set_lim   = 1'b1;
            rem_nxt   = '0;
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_ISSUE;
          end
        end else if (!dcm_locked) begin
          rem_nxt   = '0;
          state_nxt = ST_IDLE;
        end else if (tmr_tc) begin
          set_to    = 1'b1;
          rem_nxt   = '0;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from next-state so PSEN/busy align with the state.
  always_ff @(posedge dcm_psclk) begin
    if (ctrl_reset) begin
      rem          <= '0;
      dcm_psincdec <= 1'b0;
      phase_offset <= '0;
      dcm_psen     <= 1'b0;
      busy         <= 1'b0;
      err_timeout  <= 1'b0;
      err_limit    <= 1'b0;
    end else begin
      rem          <= rem_nxt;
      dcm_psincdec <= dir_nxt;
      phase_offset <= off_nxt;
      dcm_psen     <= (state_nxt == ST_ISSUE);
      busy         <= (state_nxt != ST_IDLE);
      // a new error in the same cycle as err_clr stays set
      err_timeout  <= set_to  | (err_timeout & ~err_clr);
      err_limit    <= set_lim | (err_limit   & ~err_clr);
    end
  end

endmodule

// File: tb/tb_dcm_phase_shift_ctrl.sv
module tb_dcm_phase_shift_ctrl;

  localparam int T = 1023;

  logic              dcm_psclk = 1'b0;
  logic              ctrl_reset = 1'b1;
  logic              dcm_locked = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_dir = 1'b0;
  logic [7:0]        cmd_steps = '0;
  logic              err_clr = 1'b0;
  logic              dcm_psen;
  logic              dcm_psincdec;
  logic              dcm_psdone = 1'b0;
  logic signed [9:0] phase_offset;
  logic              busy;
  logic              err_timeout;
  logic              err_limit;

  int n_chk = 0;
  int n_fail = 0;

  dcm_phase_shift_ctrl #(
    .STEP_W(8), .OFFSET_W(10), .MAX_OFFSET(255), .DONE_TIMEOUT(T)
  ) dut (
    .dcm_psclk    (dcm_psclk),
    .ctrl_reset   (ctrl_reset),
    .dcm_locked   (dcm_locked),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_dir      (cmd_dir),
    .cmd_steps    (cmd_steps),
    .err_clr      (err_clr),
    .dcm_psen     (dcm_psen),
    .dcm_psincdec (dcm_psincdec),
    .dcm_psdone   (dcm_psdone),
    .phase_offset (phase_offset),
    .busy         (busy),
    .err_timeout  (err_timeout),
    .err_limit    (err_limit)
  );

  always #5 dcm_psclk = ~dcm_psclk;

  // DCM model: PSDONE is sampled dcm_lat rising edges after the edge that
  // launched PSEN. Also counts PSEN high cycles and rising edges.
  int   dcm_lat = 4;
  bit   dcm_mute = 1'b0;
  int   dcm_cnt = 0;
  int   psen_high = 0;
  int   psen_rise = 0;
  logic psen_prev = 1'b0;

  always @(negedge dcm_psclk) begin
    dcm_psdone = 1'b0;
    if (dcm_cnt > 0) begin
      dcm_cnt--;
      if (dcm_cnt == 0) dcm_psdone = 1'b1;
    end
    if (dcm_psen === 1'b1 && !dcm_mute) dcm_cnt = dcm_lat - 1;
    if (dcm_psen === 1'b1) begin
      psen_high++;
      if (psen_prev !== 1'b1) psen_rise++;
    end
    psen_prev = dcm_psen;
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge dcm_psclk);
    #1;
  endtask

  // Present a command for one edge; returns 1ns after the accepting edge.
  task automatic send(input logic dir, input logic [7:0] steps);
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_steps = steps;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit && busy; i++) tick();
  endtask

  int base_r, base_h;

  initial begin
    // ---- reset ----
    repeat (3) tick();
    ctrl_reset = 1'b0;
    tick();
    check("rst_psen", dcm_psen, 0);
    check("rst_psincdec", dcm_psincdec, 0);
    check("rst_offset", phase_offset, 0);
    check("rst_busy", busy, 0);
    check("rst_err_timeout", err_timeout, 0);
    check("rst_err_limit", err_limit, 0);
    check("rst_cmd_ready_unlocked", cmd_ready, 0);
    dcm_locked = 1'b1;
    #1;
    check("cmd_ready_locked", cmd_ready, 1);

    // ---- 3 increments, PSDONE 4 edges after each PSEN ----
    dcm_lat = 4;
    base_r = psen_rise; base_h = psen_high;
    send(1'b1, 8'd3);
    check("t1_psen_first", dcm_psen, 1);
    check("t1_psincdec", dcm_psincdec, 1);
    check("t1_busy", busy, 1);
    check("t1_cmd_ready_low", cmd_ready, 0);
    repeat (11) tick();
    check("t1_busy_before_last_done", busy, 1);
    check("t1_offset_before_last_done", phase_offset, 2);
    tick();
    check("t1_busy_after_last_done", busy, 0);
    check("t1_offset", phase_offset, 3);
    check("t1_cmd_ready_back", cmd_ready, 1);
    check("t1_pulse_rises", psen_rise - base_r, 3);
    check("t1_pulse_cycles", psen_high - base_h, 3);

    // ---- reach +254, then hit the +255 limit ----
    dcm_lat = 2;
    send(1'b1, 8'd251);
    wait_idle(1000);
    check("t2_offset_254", phase_offset, 254);
    check("t2_no_limit_yet", err_limit, 0);
    base_r = psen_rise;
    send(1'b1, 8'd5);
    wait_idle(100);
    check("t2_busy", busy, 0);
    check("t2_pulses", psen_rise - base_r, 1);
    check("t2_offset_255", phase_offset, 255);
    check("t2_err_limit", err_limit, 1);
    check("t2_cmd_ready", cmd_ready, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t2_err_clr", err_limit, 0);
    // already on the limit: rejected at acceptance, no pulse
    base_r = psen_rise;
    send(1'b1, 8'd1);
    tick();
    check("t2b_busy", busy, 0);
    check("t2b_err_limit", err_limit, 1);
    check("t2b_pulses", psen_rise - base_r, 0);
    check("t2b_offset", phase_offset, 255);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // ---- PSDONE never arrives ----
    dcm_mute = 1'b1;
    send(1'b0, 8'd1);
    repeat (T + 1) tick();
    check("t3_no_timeout_yet", err_timeout, 0);
    check("t3_busy_waiting", busy, 1);
    tick();
    check("t3_err_timeout", err_timeout, 1);
    check("t3_busy", busy, 0);
    check("t3_offset", phase_offset, 255);
    check("t3_cmd_ready", cmd_ready, 1);
    dcm_mute = 1'b0;

    // ---- reset while in ISSUE (err_timeout still set) ----
    dcm_lat = 4;
    send(1'b0, 8'd2);
    check("t4_psen_issue", dcm_psen, 1);
    ctrl_reset = 1'b1;
    tick();
    ctrl_reset = 1'b0;
    check("t4_psen", dcm_psen, 0);
    check("t4_offset", phase_offset, 0);
    check("t4_busy", busy, 0);
    check("t4_err_timeout", err_timeout, 0);
    check("t4_err_limit", err_limit, 0);
    repeat (6) tick();
    check("t4_late_done_ignored", phase_offset, 0);

    // ---- unlock during WAIT_DONE of a 10-step decrement ----
    send(1'b0, 8'd10);
    repeat (15) tick();
    check("t5_offset_m3", phase_offset, -3);
    tick();
    check("t5_offset_m4", phase_offset, -4);
    check("t5_psen_5th", dcm_psen, 1);
    repeat (2) tick();
    check("t5_in_wait", busy, 1);
    dcm_locked = 1'b0;
    tick();
    check("t5_abort_busy", busy, 0);
    check("t5_abort_offset", phase_offset, -4);
    check("t5_no_timeout", err_timeout, 0);
    check("t5_no_limit", err_limit, 0);
    check("t5_cmd_ready_unlocked", cmd_ready, 0);
    repeat (3) tick();
    check("t5_offset_after_late_done", phase_offset, -4);
    check("t5_cmd_ready_still_low", cmd_ready, 0);
    dcm_locked = 1'b1;
    #1;
    check("t5_cmd_ready_relock", cmd_ready, 1);

    // ---- PSDONE in the timeout cycle wins ----
    dcm_lat = T + 2;
    send(1'b1, 8'd1);
    repeat (T + 1) tick();
    check("t6_busy_waiting", busy, 1);
    check("t6_offset_waiting", phase_offset, -4);
    tick();
    check("t6_busy", busy, 0);
    check("t6_offset", phase_offset, -3);
    check("t6_no_timeout", err_timeout, 0);

    // ---- zero-step command ----
    dcm_lat = 4;
    base_r = psen_rise;
    send(1'b0, 8'd0);
    check("t7_busy", busy, 0);
    check("t7_cmd_ready", cmd_ready, 1);
    repeat (3) tick();
    check("t7_pulses", psen_rise - base_r, 0);
    check("t7_offset", phase_offset, -3);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
